// File: rtl/generic_dec_dispatch_pkg.sv
// Shared types and width helpers for the lane dispatcher.
// calc_size / calc_cnt_w are also used by the find-first-set based arbiters
// so that encoder and decoder agree on index and count widths.
package generic_dec_dispatch_pkg;

  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxIdxW  = 6;
  localparam int unsigned MaxDataW = 32;

  // Width of a binary lane index; never narrower than one bit.
  function automatic int unsigned calc_size(int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Width of a counter that must be able to hold the value 'width'.
  function automatic int unsigned calc_cnt_w(int unsigned width);
    return $clog2(width + 1);
  endfunction

  // One input beat, sized for the largest supported configuration.
  typedef struct packed {
    logic [MaxIdxW-1:0]  idx;
    logic                bcast;
    logic [MaxDataW-1:0] data;
  } dispatch_beat_t;

endpackage

// File: rtl/generic_dec_dispatch_if.sv
// Handshake bundle between the beat source, the dispatcher and the lane consumers.
//   in_valid/in_ready/in_idx/in_bcast/in_data : encoded input beat
//   out_valid/out_ready/out_data              : per-lane output handshakes
// master: source + consumers side; slave: the dispatcher.
interface generic_dec_dispatch_if
  import generic_dec_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SIZE       = calc_size(WIDTH),
  parameter int unsigned DATA_WIDTH = 4
);

  logic                             in_valid;
  logic                             in_ready;
  logic [SIZE-1:0]                  in_idx;
  logic                             in_bcast;
  logic [DATA_WIDTH-1:0]            in_data;
  logic [WIDTH-1:0]                 out_valid;
  logic [WIDTH-1:0]                 out_ready;
  logic [WIDTH-1:0][DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_idx, in_bcast, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_idx, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/generic_dec_dispatch_lane_reg.sv
// One-entry holding register for a single output lane.
//   clk, reset_n : clock, async active-low reset
//   flush        : clear valid (highest priority)
//   load         : capture load_data and set valid
//   ready        : consumer ready; drains the entry when valid
//   valid, data  : held entry
//   free         : entry can accept a load this cycle (empty or draining)
//   valid_next   : value valid takes at the next edge
module dispatch_lane_reg #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  free,
  output logic                  valid_next
);

  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Data only changes on load, so it is stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid      = valid_q;
  assign data       = data_q;
  assign free       = !valid_q || ready;
  assign valid_next = valid_d;

endmodule

// File: rtl/generic_dec_dispatch.sv
// Decodes (binary lane index, data) beats and delivers each to the addressed lane,
// or to every lane on broadcast.
//   clk, reset_n : clock, async active-low reset
//   bus          : input beat handshake and per-lane output handshakes (slave side)
//   flush        : synchronous clear of all lanes; blocks input that cycle
//   err_clr      : clears err_sticky (a simultaneous set wins)
//   err_sticky   : an out-of-range unicast beat was accepted
//   any_valid    : some lane is full
//   occupancy    : number of full lanes
module generic_dec_dispatch
  import generic_dec_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SIZE       = calc_size(WIDTH),
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_W      = calc_cnt_w(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  generic_dec_dispatch_if.slave bus,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  err_sticky,
  output logic                  any_valid,
  output logic [CNT_W-1:0]      occupancy
);

  logic [WIDTH-1:0]                 sel;
  logic [WIDTH-1:0]                 free;
  logic [WIDTH-1:0]                 load;
  logic [WIDTH-1:0]                 valid_next;
  logic [WIDTH-1:0]                 lane_valid;
  logic [WIDTH-1:0][DATA_WIDTH-1:0] lane_data;
  logic [31:0]                      idx_ext;
  logic                             in_range;
  logic                             in_ready;
  logic                             accept;
  logic                             err_set;
  logic                             err_d, err_q;
  logic [CNT_W-1:0]                 occ_d, occ_q;
  logic                             any_d, any_q;

  // Index decode; an out-of-range index selects no lane.
  always_comb begin
    idx_ext  = 32'(bus.in_idx);
    in_range = idx_ext < WIDTH;
    sel      = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      sel[k] = (idx_ext == k);
    end
  end

  // in_ready never looks at in_valid, so the source may wait on it.
  always_comb begin
    in_ready = 1'b1;
    if (flush) begin
      in_ready = 1'b0;
    end else if (bus.in_bcast) begin
      in_ready = &free;
    end else if (in_range) begin
      in_ready = |(sel & free);
    end
  end

  assign accept  = bus.in_valid && in_ready;
  assign err_set = accept && !bus.in_bcast && !in_range;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      load[k] = accept && (bus.in_bcast || sel[k]);
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    dispatch_lane_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .load       (load[k]),
      .ready      (bus.out_ready[k]),
      .load_data  (bus.in_data),
      .valid      (lane_valid[k]),
      .data       (lane_data[k]),
      .free       (free[k]),
      .valid_next (valid_next[k])
    );
  end

  // Occupancy tracks the lane state that will exist after this edge.
  always_comb begin
    occ_d = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      occ_d = occ_d + CNT_W'(valid_next[k]);
    end
    any_d = |valid_next;
  end

  assign err_d = err_set || (err_q && !err_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
      occ_q <= '0;
      any_q <= 1'b0;
    end else begin
      err_q <= err_d;
      occ_q <= occ_d;
      any_q <= any_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = lane_valid;
  assign bus.out_data  = lane_data;
  assign err_sticky    = err_q;
  assign any_valid     = any_q;
  assign occupancy     = occ_q;

endmodule
